// File: rtl/pipe_ctrl_pkg.sv
// Pipeline control shared constants.
// Holds the hold/run levels, the zero word and the per-stage stall-vector
// patterns used by the hazard controller and the pipeline registers.
package pipe_ctrl_pkg;

  localparam logic       STOP      = 1'b1;
  localparam logic       NO_STOP   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam int unsigned STALL_W = 6;
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus.
// master: pipeline side, drives stall/flush requests and the redirect target,
//         receives the stall vector, flush pulse, redirect PC and watchdog state.
// slave : pipe_ctrl itself.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic               stallreq_from_if;
  logic               stallreq_from_id;
  logic               stallreq_from_ex;
  logic               stallreq_from_mem;
  logic               flush_req;
  logic [31:0]        new_pc_i;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [31:0]        new_pc;
  logic               stall_timeout;
  logic [31:0]        stall_cycles;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output flush_req, new_pc_i,
    input  stall, flush, new_pc, stall_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  flush_req, new_pc_i,
    output stall, flush, new_pc, stall_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / flush controller.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - pipe_ctrl_if.slave: stage stall requests, flush request + target in;
//          stall vector, flush pulse, redirect PC, watchdog flag and
//          stalled-cycle counter out.
// The stall vector is combinational from the requests; the deepest holding
// stage wins and every earlier stage holds with it. Bubble insertion is left
// to the pipeline registers. A flush takes one cycle in FLUSH during which
// nothing stalls and further flush requests are dropped.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [STALL_W-1:0] stall_d;
  logic [31:0]        pc_q;
  logic [7:0]         wd_q;
  logic               to_q;
  logic [31:0]        cyc_q;
  logic               take_flush;

  always_comb begin
    state_d    = state_q;
    stall_d    = STALL_NONE;
    take_flush = 1'b0;
    case (state_q)
      ST_RUN: begin
        if      (bus.stallreq_from_mem) stall_d = STALL_MEM;
        else if (bus.stallreq_from_ex)  stall_d = STALL_EX;
        else if (bus.stallreq_from_id)  stall_d = STALL_ID;
        else if (bus.stallreq_from_if)  stall_d = STALL_IF;
        // flush wins at the edge even when a stage is holding this cycle
        if (bus.flush_req) begin
          take_flush = 1'b1;
          state_d    = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    // requests are masked combinationally while reset is held
    if (!rst) stall_d = STALL_NONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      if (take_flush) pc_q <= bus.new_pc_i;
    end
  end

  // watchdog: counts consecutive stalled cycles, saturating; sticky timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= 8'd0;
      to_q  <= 1'b0;
      cyc_q <= ZERO_WORD;
    end else if (stall_d[0] == STOP) begin
      if (wd_q != 8'hFF) wd_q <= wd_q + 8'd1;
      if (wd_q == LIMIT) to_q <= 1'b1;
      cyc_q <= cyc_q + 32'd1;
    end else begin
      wd_q <= 8'd0;
    end
  end

  assign bus.stall         = stall_d;
  assign bus.flush         = (state_q == ST_FLUSH);
  assign bus.new_pc        = pc_q;
  assign bus.stall_timeout = to_q;
  assign bus.stall_cycles  = cyc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();
  pipe_ctrl #(.STALL_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_v(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] act);
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty actual=%h", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
      end
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic fr, input logic [31:0] pc);
    bus.stallreq_from_if  = req[0];
    bus.stallreq_from_id  = req[1];
    bus.stallreq_from_ex  = req[2];
    bus.stallreq_from_mem = req[3];
    bus.flush_req         = fr;
    bus.new_pc_i          = pc;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(4'b0000, 1'b0, 32'h0);
    #7;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // req = {mem, ex, id, if}; stall checked mid-cycle, the rest after the edge
  typedef struct {
    logic [3:0]  req;
    logic        fr;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [31:0] e_cyc;
  } vec_t;
  vec_t vt[13];

  initial begin
    vt[0]  = '{4'b0000, 1'b0, 32'h0,  6'b000000, 1'b0, 32'h00, 32'd0};
    vt[1]  = '{4'b1010, 1'b0, 32'h0,  6'b011111, 1'b0, 32'h00, 32'd1};
    vt[2]  = '{4'b0010, 1'b0, 32'h0,  6'b000111, 1'b0, 32'h00, 32'd2};
    vt[3]  = '{4'b0001, 1'b0, 32'h0,  6'b000011, 1'b0, 32'h00, 32'd3};
    vt[4]  = '{4'b0101, 1'b0, 32'h0,  6'b001111, 1'b0, 32'h00, 32'd4};
    vt[5]  = '{4'b0000, 1'b0, 32'h0,  6'b000000, 1'b0, 32'h00, 32'd4};
    vt[6]  = '{4'b0000, 1'b1, 32'h20, 6'b000000, 1'b1, 32'h20, 32'd4};
    vt[7]  = '{4'b1000, 1'b1, 32'h40, 6'b000000, 1'b0, 32'h20, 32'd4};
    vt[8]  = '{4'b1000, 1'b0, 32'h0,  6'b011111, 1'b0, 32'h20, 32'd5};
    vt[9]  = '{4'b0100, 1'b1, 32'h80, 6'b001111, 1'b1, 32'h80, 32'd6};
    vt[10] = '{4'b0100, 1'b0, 32'h0,  6'b000000, 1'b0, 32'h80, 32'd6};
    vt[11] = '{4'b0100, 1'b0, 32'h0,  6'b001111, 1'b0, 32'h80, 32'd7};
    vt[12] = '{4'b0000, 1'b0, 32'h0,  6'b000000, 1'b0, 32'h80, 32'd7};

    // reset state, requests ignored while held
    drive(4'b1111, 1'b1, 32'hDEAD_BEEF);
    #2;
    expect_v("rst_stall", 32'h0);         check(32'(bus.stall));
    expect_v("rst_flush", 32'h0);         check(32'(bus.flush));
    expect_v("rst_new_pc", 32'h0);        check(bus.new_pc);
    expect_v("rst_timeout", 32'h0);       check(32'(bus.stall_timeout));
    expect_v("rst_cycles", 32'h0);        check(bus.stall_cycles);
    @(posedge clk); #1;
    expect_v("rst_hold_flush", 32'h0);    check(32'(bus.flush));
    do_reset();

    // table-driven priority / flush vectors
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vt[i].req, vt[i].fr, vt[i].pc);
      expect_v($sformatf("v%0d_stall", i), 32'(vt[i].e_stall));
      #1 check(32'(bus.stall));
      @(posedge clk); #1;
      expect_v($sformatf("v%0d_flush", i), 32'(vt[i].e_flush));
      check(32'(bus.flush));
      expect_v($sformatf("v%0d_new_pc", i), vt[i].e_pc);
      check(bus.new_pc);
      expect_v($sformatf("v%0d_cycles", i), vt[i].e_cyc);
      check(bus.stall_cycles);
      expect_v($sformatf("v%0d_timeout", i), 32'h0);
      check(32'(bus.stall_timeout));
    end

    // watchdog with limit 4: 3-cycle burst, gap, 5-cycle burst
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(4'b0100, 1'b0, 32'h0);
      @(posedge clk); #1;
      expect_v($sformatf("wd_b1_%0d", k), 32'h0); check(32'(bus.stall_timeout));
    end
    @(negedge clk); drive(4'b0000, 1'b0, 32'h0);
    @(posedge clk); #1;
    expect_v("wd_gap", 32'h0); check(32'(bus.stall_timeout));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); drive(4'b0100, 1'b0, 32'h0);
      @(posedge clk); #1;
      expect_v($sformatf("wd_b2_%0d", k), (k == 4) ? 32'h1 : 32'h0);
      check(32'(bus.stall_timeout));
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); drive(4'b0000, 1'b0, 32'h0);
      @(posedge clk); #1;
      expect_v($sformatf("wd_sticky_%0d", k), 32'h1); check(32'(bus.stall_timeout));
    end

    // stall_cycles wrap from a preloaded value
    do_reset();
    @(negedge clk);
    force dut.cyc_q = 32'hFFFF_FFFE;
    #1 release dut.cyc_q;
    @(posedge clk); #1;
    expect_v("cyc_preload", 32'hFFFF_FFFE); check(bus.stall_cycles);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(4'b0100, 1'b0, 32'h0);
      @(posedge clk); #1;
      expect_v($sformatf("cyc_wrap_%0d", k), 32'hFFFF_FFFF + 32'(k)); check(bus.stall_cycles);
    end

    // async reset in the middle of a FLUSH cycle
    do_reset();
    @(negedge clk); drive(4'b0010, 1'b0, 32'h0);
    @(negedge clk); drive(4'b0000, 1'b1, 32'h100);
    @(posedge clk); #1;
    expect_v("ar_flush_on", 32'h1);       check(32'(bus.flush));
    expect_v("ar_cycles_pre", 32'h1);     check(bus.stall_cycles);
    drive(4'b0000, 1'b0, 32'h0);
    #2 rst = 1'b0;
    #1;
    expect_v("ar_flush_off", 32'h0);      check(32'(bus.flush));
    expect_v("ar_cycles_clr", 32'h0);     check(bus.stall_cycles);
    expect_v("ar_new_pc_clr", 32'h0);     check(bus.new_pc);
    @(negedge clk); rst = 1'b1;
    drive(4'b0010, 1'b0, 32'h0);
    #1;
    expect_v("ar_run_after", 32'(STALL_ID)); check(32'(bus.stall));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 255; consecutive stalled cycles before the watchdog fires (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port stallreq_from_if, input, 1; the fetch stage requests a hold.
REQ-005 SHALL have port stallreq_from_id, input, 1; the decode stage requests a hold (load-use).
REQ-006 SHALL have port stallreq_from_ex, input, 1; the execute stage requests a hold (multi-cycle op).
REQ-007 SHALL have port stallreq_from_mem, input, 1; the memory stage requests a hold.
REQ-008 SHALL have port flush_req, input, 1; exception or eret pipeline flush request.
REQ-009 SHALL have port new_pc_i, input, 32; redirect target sampled with flush_req.
REQ-010 SHALL have port stall, output, 6; per-stage hold vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-011 SHALL have port flush, output, 1; one-cycle registered flush pulse to every pipeline register.
REQ-012 SHALL have port new_pc, output, 32; registered redirect target, valid while flush=1.
REQ-013 SHALL have port stall_timeout, output, 1; sticky watchdog flag.
REQ-014 SHALL have port stall_cycles, output, 32; free-running count of stalled cycles.

Function
REQ-015 SHALL run an FSM with two states: RUN and FLUSH.
REQ-016 In RUN, stall SHALL be combinational from the requests, highest stage wins: mem 011111, ex 001111, id 000111, if 000011, none 000000.
REQ-017 stall[5] SHALL always be 0; WB never holds.
REQ-018 A stage holding while the next stage runs SHALL let that pipeline register insert a bubble; this block SHALL only generate the vector and SHALL NOT insert bubbles itself.
REQ-019 flush_req=1 at a rising edge in RUN SHALL move the FSM to FLUSH, set flush=1 and capture new_pc_i into new_pc; latency is 1 cycle.
REQ-020 In FLUSH, stall SHALL be 000000 regardless of requests, and flush_req SHALL be ignored.
REQ-021 FLUSH SHALL last exactly one cycle, then return to RUN with flush=0; new_pc SHALL hold its value.
REQ-022 flush_req together with any stall request in the same cycle: stall SHALL follow REQ-016 for that cycle, and the flush SHALL still be taken at the edge.
REQ-023 A watchdog counter (8 bits) SHALL increment each cycle stall[0]=1 and clear to 0 on any cycle stall[0]=0; it SHALL saturate at 255.
REQ-024 When the counter equals STALL_LIMIT at a rising edge with stall[0]=1, stall_timeout SHALL set and remain 1 until reset.
REQ-025 stall_cycles SHALL increment by 1 for each cycle stall[0]=1 and wrap from 0xFFFFFFFF to 0.

Reset
REQ-026 Asserting rst (low) SHALL immediately force state RUN, flush=0, new_pc=0x00000000, the watchdog counter to 0, stall_timeout=0 and stall_cycles=0.
REQ-027 While rst is low, stall SHALL be 000000; requests SHALL be ignored.
REQ-028 Reset asserted during FLUSH SHALL drop flush in the same cycle; after release, the FSM SHALL start in RUN.

Structure
REQ-029 The shared defines file SHALL hold Stop/NoStop, ZeroWord and the stall-vector patterns as named constants; the FSM state encoding SHALL stay local to this block.
REQ-030 The block SHALL be one module with no sub-modules.

Verification
REQ-031 Priority: assert id and mem requests together -> stall=011111; drop mem -> 000111; drop all -> 000000.
REQ-032 Flush: flush_req=1 with new_pc_i=0x00000020 for one cycle -> next cycle flush=1, new_pc=0x00000020, stall=000000; following cycle flush=0.
REQ-033 Flush with stall: ex request held and flush_req pulsed -> same cycle stall=001111; next cycle flush=1, stall=000000; then stall=001111 again.
REQ-034 Watchdog: STALL_LIMIT=4, ex request held for 3 cycles, released, then held for 5 cycles -> stall_timeout=0 after the first burst and 1 after the 5th cycle, staying 1 after release.
REQ-035 Counter: stall_cycles preloaded by forcing to 0xFFFFFFFE, then 3 stalled cycles -> 0xFFFFFFFF, 0x00000000, 0x00000001.
REQ-036 Async reset: drop rst mid-cycle during FLUSH -> flush=0 and stall_cycles=0 before the next clock edge.
